spi_flash_id_responder: RTL and testbench
=========================================

// Module: spi_flash_id_responder
// PURPOSE
//  SPI slave that answers the RDID (0x9F) command like the M25P16 serial PROM: it returns the
//  manufacturer ID, memory type and memory capacity bytes. It is the responder end of the
//  rdid_top SPI master link. It runs on the board clock and oversamples SPICLK/SPIMOSI/cs_n.
//  Use it as a synthesizable loopback target and as a lightweight bench model.
// PARAMETERS
//  MAN_ID       8'h20  first byte returned after RDID opcode (manufacturer ID)
//  MEM_TYPE     8'h20  second byte returned (memory type)
//  MEM_CAP      8'h15  third byte returned (memory capacity)
//  SYNC_STAGES  2      synchronizer flops on SPICLK, SPIMOSI, cs_n (min 2)
// PORTS
//  CCLK       in   1  system clock; must be >= 4x SPICLK frequency
//  reset_n    in   1  asynchronous, active-low reset
//  SPICLK     in   1  SPI serial clock from master (mode 0: idle low)
//  SPIMOSI    in   1  master-out data, MSB first
//  cs_n       in   1  chip select from master, active low
//  SPIMISO    out  1  slave-out data, MSB first
//  miso_oe    out  1  1 = SPIMISO driven; pad logic tristates when 0
//  cmd_byte   out  8  last complete opcode received
//  cmd_valid  out  1  one-CCLK pulse when 8th opcode bit is captured
//  bad_cmd    out  1  one-CCLK pulse coincident with cmd_valid when opcode != 8'h9F
//  rdid_done  out  1  one-CCLK pulse when last bit of MEM_CAP has been shifted out
//  busy       out  1  1 while cs_n (synchronized) is low
// BEHAVIOUR
//  Reset: all outputs 0 except SPIMISO=1; cmd_byte=8'h00; FSM=IDLE; bit/byte counters cleared.
//  Edge detect: sck_rise/sck_fall/cs_fall/cs_rise are 1-cycle strobes taken from the last two
//  synchronized samples. Detect latency = SYNC_STAGES+1 CCLK after the pin changes.
//  FSM states:
//   IDLE   : miso_oe=0. On cs_fall, clear bit_cnt and go to CMD.
//   CMD    : on each sck_rise, shift SPIMOSI into shreg[0] (MSB first); bit_cnt++.
//            On the 8th sck_rise: cmd_byte<=shreg, cmd_valid=1.
//              If the opcode is 9F: load tx_reg=MAN_ID, byte_cnt=0, go to ID_OUT.
//              Otherwise: bad_cmd=1, go to IGNORE.
//   ID_OUT : on the first sck_fall after entry: miso_oe=1, SPIMISO=tx_reg[7]. On each
//            following sck_fall, shift tx_reg left and drive the new tx_reg[7]. After 8 falls
//            (one byte), load the next byte: MEM_TYPE, then MEM_CAP, then 8'h00 forever.
//            rdid_done pulses on the sck_fall that would begin the 4th byte.
//   IGNORE : miso_oe=0; SPICLK/SPIMOSI are ignored until cs_rise.
//  cs_rise in any state: go to IDLE on the next CCLK, miso_oe=0, SPIMISO=1, counters cleared.
//  A partial opcode (<8 bits) gives no cmd_valid; cmd_byte keeps its old value.
//  cs_rise and sck_rise in the same cycle: cs_rise wins and the bit is discarded.
//  Glitch rule: sck edges are qualified only while synchronized cs_n=0.
//  Counters: bit_cnt is 3 bits and wraps 7->0. byte_cnt is 2 bits and saturates at 3 (= 8'h00 phase).
//  reset_n asserted mid-transfer: immediate return to reset values. The transaction is not
//  resumed; the master must deassert cs_n and restart.
//  Pulses never exceed one CCLK. busy follows synchronized cs_n with detect latency.
// TESTING
//  T1 RDID: CCLK 50 MHz, SPICLK 1 MHz, cs_n low, send 9F then 24 clocks -> MISO bytes
//     20,20,15; cmd_byte=9F; cmd_valid x1; rdid_done x1; bad_cmd never pulses.
//  T2 back-to-back RDID: cs_n high 1 us between two transactions -> identical 20,20,15 both
//     times; miso_oe=0 during the gap.
//  T3 over-read: RDID followed by 40 clocks -> bytes 20,20,15,00,00; rdid_done pulses once.
//  T4 bad opcode 05 followed by 16 clocks -> cmd_valid and bad_cmd pulse together;
//     cmd_byte=05; miso_oe stays 0 and SPIMISO=1 throughout.
//  T5 abort: cs_n raised after 4 opcode bits, then a full RDID -> first transaction gives no
//     cmd_valid; second returns 20,20,15.
//  T6 reset_n pulsed low mid-byte 2 -> outputs reach reset values asynchronously; after cs_n
//     cycles high and a new RDID is sent, the response is 20,20,15.

Source files
------------

// File: rtl/spi_flash_id_responder.sv
// spi_flash_id_responder: oversampled SPI mode-0 slave that answers RDID (0x9F)
// with manufacturer ID, memory type and capacity, then 8'h00 for any over-read.
module spi_flash_id_responder #(
    parameter logic [7:0]  MAN_ID      = 8'h20,
    parameter logic [7:0]  MEM_TYPE    = 8'h20,
    parameter logic [7:0]  MEM_CAP     = 8'h15,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CCLK,
    input  logic       reset_n,
    input  logic       SPICLK,
    input  logic       SPIMOSI,
    input  logic       cs_n,
    output logic       SPIMISO,
    output logic       miso_oe,
    output logic [7:0] cmd_byte,
    output logic       cmd_valid,
    output logic       bad_cmd,
    output logic       rdid_done,
    output logic       busy
);

    localparam logic [7:0] RDID_OP = 8'h9F;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        ID_OUT,
        IGNORE
    } state_t;

    // synchronizer chains; the output end is bit SYNC_STAGES-1
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;
    logic                   cs_prev;

    logic sck_s;
    logic mosi_s;
    logic cs_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [1:0] byte_cnt, byte_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] tx_reg, tx_reg_n;
    logic       first_fall, first_fall_n;
    logic       miso_n;
    logic       oe_n;
    logic [7:0] cmd_byte_n;
    logic       cmd_valid_n;
    logic       bad_cmd_n;
    logic       rdid_done_n;

    // response byte for a given byte index; index 3 is the saturated 8'h00 phase
    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = MAN_ID;
            2'd1:    id_byte = MEM_TYPE;
            2'd2:    id_byte = MEM_CAP;
            default: id_byte = 8'h00;
        endcase
    endfunction

    // pin synchronizers plus one extra sample for edge detection; cs_n idles high
    always_ff @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPICLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPIMOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // sck edges only count while the device is selected
    assign sck_rise = sck_s & ~sck_prev & ~cs_s;
    assign sck_fall = ~sck_s & sck_prev & ~cs_s;
    assign cs_fall  = ~cs_s & cs_prev;
    assign cs_rise  = cs_s & ~cs_prev;

    assign busy = ~cs_s;

    // FSM and datapath registers
    always_ff @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            tx_reg     <= '0;
            first_fall <= 1'b0;
            SPIMISO    <= 1'b1;
            miso_oe    <= 1'b0;
            cmd_byte   <= '0;
            cmd_valid  <= 1'b0;
            bad_cmd    <= 1'b0;
            rdid_done  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            shreg      <= shreg_n;
            tx_reg     <= tx_reg_n;
            first_fall <= first_fall_n;
            SPIMISO    <= miso_n;
            miso_oe    <= oe_n;
            cmd_byte   <= cmd_byte_n;
            cmd_valid  <= cmd_valid_n;
            bad_cmd    <= bad_cmd_n;
            rdid_done  <= rdid_done_n;
        end
    end

    // next-state, shift and output logic; cs_rise overrides everything else
    always_comb begin
        logic [7:0] rx_next;
        logic [1:0] byte_next;
        logic [7:0] byte_val;

        state_n      = state;
        bit_cnt_n    = bit_cnt;
        byte_cnt_n   = byte_cnt;
        shreg_n      = shreg;
        tx_reg_n     = tx_reg;
        first_fall_n = first_fall;
        miso_n       = SPIMISO;
        oe_n         = miso_oe;
        cmd_byte_n   = cmd_byte;
        cmd_valid_n  = 1'b0;
        bad_cmd_n    = 1'b0;
        rdid_done_n  = 1'b0;
        rx_next      = {shreg[6:0], mosi_s};
        byte_next    = (byte_cnt == 2'd3) ? 2'd3 : byte_cnt + 2'd1;
        byte_val     = id_byte(byte_next);

        if (cs_rise) begin
            state_n      = IDLE;
            oe_n         = 1'b0;
            miso_n       = 1'b1;
            bit_cnt_n    = '0;
            byte_cnt_n   = '0;
            first_fall_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oe_n   = 1'b0;
                    miso_n = 1'b1;
                    if (cs_fall) begin
                        bit_cnt_n = '0;
                        state_n   = CMD;
                    end
                end

                CMD: begin
                    if (sck_rise) begin
                        shreg_n   = rx_next;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            cmd_byte_n  = rx_next;
                            cmd_valid_n = 1'b1;
                            if (rx_next == RDID_OP) begin
                                tx_reg_n     = MAN_ID;
                                byte_cnt_n   = '0;
                                first_fall_n = 1'b1;
                                state_n      = ID_OUT;
                            end else begin
                                bad_cmd_n = 1'b1;
                                state_n   = IGNORE;
                            end
                        end
                    end
                end

                ID_OUT: begin
                    // bit_cnt counts bits already driven in the current byte;
                    // a wrap to 0 means the byte is finished and the next is due
                    if (sck_fall) begin
                        if (first_fall) begin
                            oe_n         = 1'b1;
                            miso_n       = tx_reg[7];
                            first_fall_n = 1'b0;
                            bit_cnt_n    = 3'd1;
                        end else if (bit_cnt == 3'd0) begin
                            tx_reg_n    = byte_val;
                            miso_n      = byte_val[7];
                            byte_cnt_n  = byte_next;
                            bit_cnt_n   = 3'd1;
                            rdid_done_n = (byte_cnt == 2'd2);
                        end else begin
                            tx_reg_n  = {tx_reg[6:0], 1'b0};
                            miso_n    = tx_reg[6];
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end

                IGNORE: begin
                    oe_n   = 1'b0;
                    miso_n = 1'b1;
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Scoreboard bench for spi_flash_id_responder: a master task drives SPI traffic
// and queues expected bytes/commands; monitors deserialize MISO and compare.
`timescale 1ns/1ps
module tb_spi_flash_id_responder;

    logic       CCLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       SPICLK = 1'b0;
    logic       SPIMOSI = 1'b0;
    logic       cs_n = 1'b1;
    logic       SPIMISO;
    logic       miso_oe;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       bad_cmd;
    logic       rdid_done;
    logic       busy;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0] byte_q[$];
    logic [8:0] cmd_q[$];
    int unsigned rdid_cnt = 0;
    logic [7:0] mon_sh = '0;
    int unsigned mon_nb = 0;
    logic quiet_watch = 1'b0;
    logic quiet_bad = 1'b0;

    spi_flash_id_responder #(
        .MAN_ID(8'h20),
        .MEM_TYPE(8'h20),
        .MEM_CAP(8'h15),
        .SYNC_STAGES(2)
    ) dut (
        .CCLK(CCLK),
        .reset_n(reset_n),
        .SPICLK(SPICLK),
        .SPIMOSI(SPIMOSI),
        .cs_n(cs_n),
        .SPIMISO(SPIMISO),
        .miso_oe(miso_oe),
        .cmd_byte(cmd_byte),
        .cmd_valid(cmd_valid),
        .bad_cmd(bad_cmd),
        .rdid_done(rdid_done),
        .busy(busy)
    );

    // 50 MHz system clock
    always #10 CCLK = ~CCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MISO deserializer: master samples on SPICLK rise while the slave drives
    always @(posedge SPICLK) begin
        if (miso_oe) begin
            mon_sh = {mon_sh[6:0], SPIMISO};
            mon_nb++;
            if (mon_nb == 8) begin
                mon_nb = 0;
                if (byte_q.size() == 0) check("unexpected_miso_byte", {24'h0, mon_sh}, 32'hFFFF_FFFF);
                else check("miso_byte", {24'h0, mon_sh}, {24'h0, byte_q.pop_front()});
            end
        end
    end

    // partial bytes are dropped when the transaction ends
    always @(posedge cs_n) mon_nb = 0;

    // command / pulse monitor sampled mid-cycle
    always @(negedge CCLK) begin
        if (cmd_valid) begin
            if (cmd_q.size() == 0) check("unexpected_cmd_valid", {23'h0, bad_cmd, cmd_byte}, 32'hFFFF_FFFF);
            else check("cmd_byte_badcmd", {23'h0, bad_cmd, cmd_byte}, {23'h0, cmd_q.pop_front()});
        end else if (bad_cmd) begin
            check("bad_cmd_without_cmd_valid", 32'd1, 32'd0);
        end
        if (rdid_done) rdid_cnt++;
        if (quiet_watch && (miso_oe || !SPIMISO)) quiet_bad = 1'b1;
    end

    task automatic spi_bit(input logic b);
        SPIMOSI = b;
        #500 SPICLK = 1'b1;
        #500 SPICLK = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic clocks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) spi_bit(1'b0);
    endtask

    task automatic sel;
        cs_n = 1'b0;
        #500;
    endtask

    task automatic desel;
        #500 cs_n = 1'b1;
        #1000;
    endtask

    // full RDID with n read clocks; expected bytes queued before traffic starts
    task automatic rdid_xfer(input int unsigned n, input int unsigned exp_done, input string tag);
        logic [7:0] exp_bytes [5];
        exp_bytes = '{8'h20, 8'h20, 8'h15, 8'h00, 8'h00};
        rdid_cnt = 0;
        for (int unsigned i = 0; i < n / 8; i++) byte_q.push_back(exp_bytes[i]);
        cmd_q.push_back({1'b0, 8'h9F});
        sel();
        send_byte(8'h9F);
        clocks(n);
        desel();
        check({tag, "_bytes_left"}, byte_q.size(), 32'd0);
        check({tag, "_cmd_left"}, cmd_q.size(), 32'd0);
        check({tag, "_rdid_done_count"}, rdid_cnt, exp_done);
    endtask

    initial begin
        // reset values
        #100;
        check("rst_SPIMISO", {31'h0, SPIMISO}, 32'd1);
        check("rst_miso_oe", {31'h0, miso_oe}, 32'd0);
        check("rst_cmd_byte", {24'h0, cmd_byte}, 32'd0);
        check("rst_pulses", {29'h0, cmd_valid, bad_cmd, rdid_done}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        reset_n = 1'b1;
        #200;

        // T1 basic RDID
        rdid_xfer(24, 1, "t1");
        check("t1_cmd_byte", {24'h0, cmd_byte}, 32'h9F);

        // T2 back-to-back with idle gap
        rdid_xfer(24, 1, "t2a");
        check("t2_gap_oe", {31'h0, miso_oe}, 32'd0);
        check("t2_gap_busy", {31'h0, busy}, 32'd0);
        rdid_xfer(24, 1, "t2b");

        // T3 over-read into the zero phase
        rdid_xfer(40, 1, "t3");

        // T4 unsupported opcode: bus must stay released
        rdid_cnt = 0;
        cmd_q.push_back({1'b1, 8'h05});
        quiet_bad = 1'b0;
        quiet_watch = 1'b1;
        sel();
        send_byte(8'h05);
        clocks(16);
        desel();
        quiet_watch = 1'b0;
        check("t4_cmd_left", cmd_q.size(), 32'd0);
        check("t4_cmd_byte", {24'h0, cmd_byte}, 32'h05);
        check("t4_bus_quiet", {31'h0, quiet_bad}, 32'd0);
        check("t4_rdid_done_count", rdid_cnt, 32'd0);

        // T5 abort after 4 opcode bits, then a full RDID
        sel();
        for (int i = 7; i >= 4; i--) begin
            logic [7:0] op;
            op = 8'h9F;
            spi_bit(op[i]);
        end
        desel();
        check("t5_cmd_byte_kept", {24'h0, cmd_byte}, 32'h05);
        rdid_xfer(24, 1, "t5");

        // T6 reset mid byte 2
        rdid_cnt = 0;
        byte_q.push_back(8'h20);
        cmd_q.push_back({1'b0, 8'h9F});
        sel();
        send_byte(8'h9F);
        clocks(12);
        #200 reset_n = 1'b0;
        #5;
        check("t6_rst_SPIMISO", {31'h0, SPIMISO}, 32'd1);
        check("t6_rst_miso_oe", {31'h0, miso_oe}, 32'd0);
        check("t6_rst_busy", {31'h0, busy}, 32'd0);
        check("t6_rst_cmd_byte", {24'h0, cmd_byte}, 32'd0);
        #100 reset_n = 1'b1;
        #200;
        desel();
        check("t6_bytes_left", byte_q.size(), 32'd0);
        check("t6_rdid_done_count", rdid_cnt, 32'd0);
        rdid_xfer(24, 1, "t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
